pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline boundary register. It generalises the fixed-field inter-stage latches (if/id, id/ex, ex/mem, mem/wb) into one block.
- Carries an opaque DATA_W-bit payload plus a valid bit.
- Obeys the shared 6-bit stall vector and adds a flush input and selectable bubble/hold mode on a partial stall.
- Also provides a saturating stall-duration counter for hazard debugging.
- Instantiated once per stage boundary in the CPU top.

Parameters:
- DATA_W, 32, payload width in bits (packed wd/wreg/wdata/op fields etc.).
- STAGE, 3, index of this register's upstream stage in the stall vector; legal range 0..STALL_W-2.
- STALL_W, 6, width of the stall vector.
- BUBBLE_ON_STALL, 1, 1: insert NOP when upstream stalls and downstream runs; 0: hold contents.
- NOP_VALUE, 0 (DATA_W bits), payload loaded on reset, flush and bubble.
- CNT_W, 8, width of the stall counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  STALL_W  global stall vector; bit=1 means stop.
- flush  input  1  kill the contents of this stage (branch redirect).
- in_valid  input  1  upstream stage output is valid.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  registered valid to downstream.
- out_data  output  DATA_W  registered payload to downstream.
- stalled  output  1  registered; 1 if the last edge did not load new data because of stall.
- stall_cnt  output  CNT_W  consecutive non-loading stall cycles, saturating.

Behaviour:
- Let up = stall[STAGE] and dn = stall[STAGE+1]. Priority per rising edge, highest first:
  1. rst=1: out_valid=0, out_data=NOP_VALUE, stalled=0, stall_cnt=0.
  2. flush=1: out_valid=0, out_data=NOP_VALUE, stalled=0, stall_cnt=0. Flush overrides any stall combination.
  3. up=1, dn=0 (partial stall):
     - BUBBLE_ON_STALL=1: out_valid=0, out_data=NOP_VALUE.
     - BUBBLE_ON_STALL=0: out_valid and out_data hold.
     - Either mode: stalled=1, stall_cnt increments.
  4. up=1, dn=1 (full stall): all payload state holds; stalled=1, stall_cnt increments.
  5. up=0, dn=1: a malformed vector. Treat as a load (rule 6) so the pipeline never deadlocks. The verification assertion flags it.
  6. up=0, dn=0 (normal): out_valid<=in_valid, out_data<=in_data, stalled=0, stall_cnt=0.
- out_data is also written with NOP_VALUE whenever a load has in_valid=0. Downstream may then ignore out_valid for write-enable decoding.
- stall_cnt saturates at 2^CNT_W-1 and does not wrap. It stays saturated until a load, flush or reset clears it.
- Latency: exactly one cycle from in_* to out_* when unstalled. There is no combinational path from any input to any output.
- Bubble mode with a sustained partial stall: the first stalled edge drops valid. Later edges keep loading NOP, which is idempotent.
- Hold mode with a partial stall: the same instruction stays visible downstream for multiple cycles. The integrator must only pick this mode for stages whose consumer is idempotent.
- Reset asserted mid-stall: reset wins in that cycle. The first edge after rst deasserts follows the normal rules.
- Elaboration check: STAGE > STALL_W-2 or DATA_W < 1 is a fatal error.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_data=0xDEADBEEF, stall=0 -> out_valid=0, out_data=0, stall_cnt=0. Release; one edge later out_valid=1, out_data=0xDEADBEEF.
- Streaming: stall=0, feed in_data 1,2,3,4 on consecutive cycles -> out_data shows 1,2,3,4 each one cycle later; stalled stays 0.
- Partial stall, STAGE=3, BUBBLE_ON_STALL=1: stall=6'b001000 for 3 cycles with out_data=0x55 beforehand -> out_valid=0, out_data=0 after the first edge; stall_cnt=1,2,3. Repeat with BUBBLE_ON_STALL=0 -> out_valid=1, out_data=0x55 held, same counts.
- Full stall plus flush: stall=6'b011000 for 2 cycles (contents held, stall_cnt=2), then flush=1 with stall unchanged -> out_valid=0, out_data=0, stall_cnt=0, stalled=0.
- Saturation, CNT_W=3: stall=6'b011000 for 10 cycles -> stall_cnt reaches 7 and stays 7. Then stall=0 -> stall_cnt=0 next edge.
- Malformed vector: stall=6'b010000 with in_data=0xA5, in_valid=1 -> loads 0xA5, out_valid=1; the assertion fires.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: carries an opaque payload plus a valid bit
// from one stage to the next, obeying the shared stall vector, a flush,
// and a bubble/hold choice on a partial stall. A saturating counter
// reports how many consecutive edges this boundary failed to load.
//
// Handshake: in_valid qualifies in_data and is sampled only on a loading
// edge (stall[STAGE]==0 and no flush); out_valid qualifies out_data, and
// out_data is NOP_VALUE whenever out_valid is 0 after a load, flush or
// bubble. There is no ready signal; back-pressure is the stall vector.
module pipe_stage_reg #(
    parameter int                  DATA_W          = 32,
    parameter int                  STAGE           = 3,
    parameter int                  STALL_W         = 6,
    parameter bit                  BUBBLE_ON_STALL = 1'b1,
    parameter logic [DATA_W-1:0]   NOP_VALUE       = '0,
    parameter int                  CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               stalled,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Reject configurations where the downstream stall bit would not exist.
    generate
        if (STAGE > STALL_W - 2 || STAGE < 0 || DATA_W < 1) begin : g_bad_param
            $fatal(1, "pipe_stage_reg: illegal STAGE/STALL_W/DATA_W combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_stalled;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_up;
    logic              w_dn;
    logic              w_nxt_valid;
    logic [DATA_W-1:0] w_nxt_data;
    logic              w_nxt_stalled;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic              w_unused_stall;

    assign w_up = stall[STAGE];
    assign w_dn = stall[STAGE+1];

    // Only two bits of the shared vector matter to this boundary.
    assign w_unused_stall = ^stall;

    // Next-state selection: flush, then upstream stall, else load.
    // A set downstream bit with a clear upstream bit falls through to the
    // load branch so a malformed vector can never wedge the pipeline.
    always_comb begin
        w_nxt_valid   = r_valid;
        w_nxt_data    = r_data;
        w_nxt_stalled = r_stalled;
        w_nxt_cnt     = r_cnt;
        if (flush) begin
            w_nxt_valid   = 1'b0;
            w_nxt_data    = NOP_VALUE;
            w_nxt_stalled = 1'b0;
            w_nxt_cnt     = '0;
        end else if (w_up) begin
            w_nxt_stalled = 1'b1;
            if (r_cnt != CNT_MAX) begin
                w_nxt_cnt = r_cnt + 1'b1;
            end
            if (!w_dn && BUBBLE_ON_STALL) begin
                w_nxt_valid = 1'b0;
                w_nxt_data  = NOP_VALUE;
            end
        end else begin
            w_nxt_valid   = in_valid;
            w_nxt_data    = in_valid ? in_data : NOP_VALUE;
            w_nxt_stalled = 1'b0;
            w_nxt_cnt     = '0;
        end
    end

    // State register; reset dominates every other condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= NOP_VALUE;
            r_stalled <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_valid   <= w_nxt_valid;
            r_data    <= w_nxt_data;
            r_stalled <= w_nxt_stalled;
            r_cnt     <= w_nxt_cnt;
        end
    end

    // Flag a stall vector where downstream stops but upstream keeps going.
    always_ff @(posedge clk) begin
        a_stall_vector_order: assert (rst || flush || !(w_dn && !w_up))
            else $warning("pipe_stage_reg: downstream stall without upstream stall");
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign stalled   = r_stalled;
    assign stall_cnt = r_cnt;

endmodule
